pc_seq_ctrl: RTL
================

// Module: pc_seq_ctrl
// PURPOSE
//  Next-PC and front-end hazard sequencer for the 5-stage pipeline. Selects npc (pc+4, J target, BEQ target).
//  Drives the active-low PC write enable and IF/ID write enable, and the IF/ID, ID/EX and EX/MEM flushes.
//  Handles load-use stalls, instruction-memory wait and a deferred redirect. Sits between ID/MEM hazard logic and the pc register.
// PARAMETERS
//  RESET_PC         32'h0000_3000  npc presented while reset is high
//  LOAD_USE_CYCLES  1              bubble cycles per load-use hazard, legal range 1..15
// PORTS
//  clock       in   1   single system clock, rising edge
//  reset       in   1   synchronous, active-high
//  pc          in   32  current PC from the pc register
//  imem_ready  in   1   instruction fetch for pc completes this cycle
//  j_valid     in   1   J instruction decoded in ID
//  j_target    in   32  J target address
//  br_taken    in   1   BEQ in MEM resolved taken
//  br_target   in   32  BEQ target address
//  load_use    in   1   ID instruction depends on a load in EX
//  npc         out  32  next PC; bits [1:0] always 2'b00
//  pc_nwrite   out  1   pc register write enable, active low
//  ifid_nwrite out  1   IF/ID write enable, active low
//  flush_ifid  out  1   IF/ID becomes a bubble at the next edge; overrides ifid_nwrite
//  flush_idex  out  1   ID/EX becomes a bubble at the next edge
//  flush_exmem out  1   EX/MEM becomes a bubble at the next edge
// BEHAVIOUR
//  - Outputs are combinational from state, counters and inputs. State, cnt[3:0] and redir_q[31:0] are registered.
//  - Reset high: next state RUN, cnt=0, redir_q=0.
//    Outputs during reset: npc=RESET_PC, pc_nwrite=1, ifid_nwrite=1, all flushes=0.
//  - Targets use {target[31:2],2'b00}. pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC goes to 0.
//  - Redirect: npc and flushes are issued in the same cycle as the request. PC takes the target at the next edge.
//  - Unlisted outputs default to: pc_nwrite=1, ifid_nwrite=1, flushes=0, npc=pc+4.
//  - Priority in RUN and STALL: br_taken > j_valid > load_use > !imem_ready > normal advance.
//  RUN state:
//   normal (imem_ready, no hazard): npc=pc+4, pc_nwrite=0, ifid_nwrite=0
//   br_taken: flush_ifid=flush_idex=flush_exmem=1
//     imem_ready=1: npc=br_target, pc_nwrite=0, stay RUN
//     imem_ready=0: redir_q<=br_target, go to PEND
//   j_valid: flush_ifid=1, with the same imem_ready split as br_taken (j_target)
//   load_use: hold PC and IF/ID; flush_idex=1
//     if LOAD_USE_CYCLES>1: cnt<=LOAD_USE_CYCLES-1, go to STALL
//   !imem_ready: hold PC and IF/ID; flush_idex=1, so no duplicate ID issue
//  STALL state:
//   each cycle: hold PC and IF/ID, flush_idex=1, cnt<=cnt-1; cnt==1 goes to RUN
//   br_taken: handled as in RUN, cnt<=0; j_valid and load_use ignored
//  PEND state:
//   PC held, flush_ifid=1; j_valid, load_use and br_taken ignored (pipeline already flushed)
//   imem_ready=1: npc=redir_q, pc_nwrite=0, flush_ifid=1, go to RUN
//  - Reset high in STALL or PEND: abandons the stall or redirect; redir_q cleared; no PC write in that cycle.
// CONFIGURATION
//  PCCTRL_STATS_EN defined:
//   adds outputs stall_cnt[15:0] (cycles with pc_nwrite=1 outside reset) and flush_cnt[15:0] (cycles with flush_ifid=1)
//   both counters saturate at 16'hFFFF and clear on reset
//  PCCTRL_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical
// TESTING
//  1. Free run, imem_ready=1, pc=32'h3000: npc=32'h3004, pc_nwrite=0, ifid_nwrite=0; pc=32'hFFFF_FFFC gives npc=0
//  2. load_use one cycle, LOAD_USE_CYCLES=3: pc_nwrite=1, flush_idex=1 for 3 cycles, then npc=pc+4 resumes
//  3. j_valid, j_target=32'h3041: npc=32'h3040, flush_ifid=1, flush_idex=0, pc_nwrite=0 in the same cycle
//  4. br_taken with j_valid and load_use also high, br_target=32'h3100: npc=32'h3100, all three flushes=1
//  5. br_taken with imem_ready=0, target 32'h3200, then imem_ready=0 for 2 cycles:
//     PC held, flush_ifid=1; when imem_ready=1, npc=32'h3200, pc_nwrite=0, state RUN
//  6. reset high while in PEND: next cycle state RUN, npc=RESET_PC; with PCCTRL_STATS_EN, stall_cnt=0 and flush_cnt=0

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// Next-PC select and front-end hazard sequencer: redirects, load-use stalls, fetch wait, deferred redirect.
// Optional PCCTRL_STATS_EN adds saturating stall_cnt / flush_cnt counters.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        imem_ready,
  input  logic        j_valid,
  input  logic [31:0] j_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        load_use,
  output logic [31:0] npc,
  output logic        pc_nwrite,
  output logic        ifid_nwrite,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem
`ifdef PCCTRL_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    PEND  = 2'd2
  } state_e;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  LU_RELOAD  = 4'(LOAD_USE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_tgt_s;
  logic [31:0] j_tgt_s;

  assign pc_plus4_s = (pc + 32'd4) & ALIGN_MASK;
  assign br_tgt_s   = br_target & ALIGN_MASK;
  assign j_tgt_s    = j_target & ALIGN_MASK;

  // Next-state and combinational output decode; reset forces a quiet, non-writing cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    redir_d     = redir_q;
    npc         = pc_plus4_s;
    pc_nwrite   = 1'b1;
    ifid_nwrite = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (reset) begin
      state_d = RUN;
      cnt_d   = 4'd0;
      redir_d = 32'd0;
      npc     = RESET_PC & ALIGN_MASK;
    end else begin
      case (state_q)
        RUN: begin
          if (br_taken || j_valid) begin
            flush_ifid = 1'b1;
            if (br_taken) begin
              flush_idex  = 1'b1;
              flush_exmem = 1'b1;
            end else begin
              flush_idex  = 1'b0;
            end
            if (imem_ready) begin
              npc       = br_taken ? br_tgt_s : j_tgt_s;
              pc_nwrite = 1'b0;
            end else begin
              redir_d = br_taken ? br_tgt_s : j_tgt_s;
              state_d = PEND;
            end
          end else if (load_use) begin
            flush_idex = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              cnt_d   = LU_RELOAD;
              state_d = STALL;
            end else begin
              state_d = RUN;
            end
          end else if (!imem_ready) begin
            // ID re-sees the same instruction next cycle, so squash what it issues now.
            flush_idex = 1'b1;
          end else begin
            pc_nwrite   = 1'b0;
            ifid_nwrite = 1'b0;
          end
        end
        STALL: begin
          flush_idex = 1'b1;
          if (br_taken) begin
            flush_ifid  = 1'b1;
            flush_exmem = 1'b1;
            cnt_d       = 4'd0;
            if (imem_ready) begin
              npc       = br_tgt_s;
              pc_nwrite = 1'b0;
              state_d   = RUN;
            end else begin
              redir_d = br_tgt_s;
              state_d = PEND;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              state_d = RUN;
            end else begin
              state_d = STALL;
            end
          end
        end
        PEND: begin
          flush_ifid = 1'b1;
          if (imem_ready) begin
            npc       = redir_q;
            pc_nwrite = 1'b0;
            state_d   = RUN;
          end else begin
            state_d = PEND;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    redir_q <= redir_d;
  end

`ifdef PCCTRL_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters; the reset cycle itself is never counted as a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (pc_nwrite) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (flush_ifid) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
